matrix_rd_port: RTL and testbench
=================================

# matrix_rd_port

Parametrised, synthesizable read-port model for the GSIM matrix-memory interface. It replaces the fixed 1024×256, always-ready, 1-cycle memory used around GSIM, and adds:
- configurable width, depth and read latency;
- a host write port for preloading;
- deterministic ready-stall modes that exercise GSIM's `o_mem_rreq` / `i_mem_rrdy` handshake;
- an accepted-read counter.

It sits between GSIM's memory master port and the pattern-loading logic.

## Interface
- `DATA_W`, 256: data word width in bits.
- `ADDR_W`, 10: address width.
- `DEPTH`, 1024: number of words; must be ≤ 2^`ADDR_W`.
- `LATENCY`, 1: cycles from request acceptance to `o_dout_vld`; legal range 1..8.
- `STALL_MODE`, 0: 0 = always ready, 1 = periodic stall, 2 = LFSR stall.
- `STALL_PERIOD`, 4: period for mode 1; legal range 2..255.

Ports (reset reset, asynchronous, active-high; clock clk):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `i_rreq`  in  1  read request from GSIM.
- `i_addr`  in  `ADDR_W`  read address.
- `o_rrdy`  out  1  port can accept a request this cycle.
- `o_dout`  out  `DATA_W`  read data; all zeros whenever `o_dout_vld` = 0.
- `o_dout_vld`  out  1  `o_dout` valid, one-cycle pulse per accepted read.
- `i_stall_en`  in  1  enables stall generation; when 0, `o_rrdy` = 1 in every mode.
- `i_wen`  in  1  preload write enable.
- `i_waddr`  in  `ADDR_W`  preload address.
- `i_wdata`  in  `DATA_W`  preload data.
- `o_rd_cnt`  out  32  number of accepted reads since reset; wraps modulo 2^32.

## Operation
- **Accept:** a request is accepted at a rising edge where `i_rreq` = 1 and `o_rrdy` = 1. A request with `o_rrdy` = 0 is ignored, not queued; the master must hold or reissue it.
- **Read sampling:** the array is read at the accepting edge. Data and the valid bit travel through a `LATENCY`-stage pipeline. Back-to-back requests are accepted every cycle, so up to `LATENCY` reads are in flight.
- **Read/write collision:** the port is read-first. If `i_wen` hits the address being accepted at the same edge, the read returns the old word. Writes are accepted regardless of `o_rrdy`.
- **Out-of-range:** an address ≥ `DEPTH` is accepted normally and returns all zeros. An out-of-range write is dropped.
- **Array contents:** the array is not reset.
- **Stall mode 0:** `o_rrdy` = 1.
- **Stall mode 1:**
  - An 8-bit phase counter runs 0..`STALL_PERIOD`−1 and wraps.
  - `o_rrdy` = 0 only while phase = `STALL_PERIOD`−1.
  - The counter advances every cycle, independent of requests.
- **Stall mode 2:**
  - A 16-bit Fibonacci LFSR with taps 16, 14, 13, 11 and seed 16'hACE1 shifts every cycle.
  - `o_rrdy` = 0 while `lfsr[1:0]` = 2'b00.
- **`i_stall_en` = 0:** the phase counter and LFSR keep running, but `o_rrdy` is forced to 1.
- **`o_rd_cnt`:** increments by 1 at each accepting edge.

## Timing
- **Reset values:** `o_rrdy` = 1, `o_dout` = 0, `o_dout_vld` = 0, `o_rd_cnt` = 0. Pipeline valid bits are cleared, the phase counter is 0, and the LFSR holds the seed.
- **Reset mid-operation:** all in-flight reads are discarded. No `o_dout_vld` is produced for a request accepted before reset asserted.
- **Latency:** a request accepted at edge k gives `o_dout_vld` = 1 with its data from edge k+`LATENCY`−1 until edge k+`LATENCY`. With `LATENCY` = 1, data is visible in the cycle immediately after acceptance, which matches the legacy behaviour.
- **Ready path:** `o_rrdy` is a registered output, with no combinational path from `i_rreq` or `i_addr`.
- **Output path:** `o_dout` and `o_dout_vld` are registered; `o_dout` is masked to zero when not valid.
- **Ordering:** one response per accepted request, returned in order with a fixed latency. There is no backpressure on the response side.

## Structure
- **Package `matrix_mem_pkg`:**
  - stall-mode constants `STALL_NONE`, `STALL_PERIODIC`, `STALL_LFSR`;
  - `LFSR_SEED` = 16'hACE1 and the LFSR tap mask;
  - `MAX_LATENCY` = 8.
- **Sub-module `matrix_rd_pipe`:**
  - parametrised on `DATA_W` and `LATENCY`;
  - a valid+data shift pipeline with async reset on the valid bits and zero-masking at its output.
- **Top level:** holds the array, the accept logic, the stall generator and the counter.

## Test plan
- **Preload and sequential read:** preload `addr[i]` = {8{i}} for i = 0..15, `LATENCY` = 1, mode 0; request addresses 0..15 back-to-back → 16 consecutive `o_dout_vld` pulses starting the cycle after the first accept, data in order, `o_rd_cnt` = 16.
- **Latency 4:** `LATENCY` = 4, single read of addr 5 at edge 10 → `o_dout_vld` high only between edges 13 and 14 with the preloaded value; `o_dout` = 0 in every other cycle.
- **Periodic stall:** mode 1, `STALL_PERIOD` = 4, `i_rreq` held high → `o_rrdy` low every 4th cycle, exactly 3 accepts per 4 cycles, ignored cycles produce no response, `o_rd_cnt` matches the vld pulse count.
- **Collision and range:** simultaneous write 0xFF…F and read of addr 7 (old value 0x07…) → the read returns 0x07…, and a second read returns 0xFF…F. A read of addr ≥ `DEPTH` (build with `DEPTH` = 512) returns 0.
- **Reset with reads in flight:** `LATENCY` = 3, two reads accepted, `reset` pulsed before the data returns → no `o_dout_vld` afterwards, all outputs at their reset values, `o_rrdy` = 1.
- **LFSR stall:** mode 2 → `o_rrdy` sequence matches the reference LFSR model for 1000 cycles; with `i_stall_en` = 0, `o_rrdy` stays 1.

Source files
------------

// File: rtl/matrix_mem_pkg.sv
// Shared constants for the GSIM matrix-memory read port: stall modes,
// LFSR definition and the latency ceiling.
package matrix_mem_pkg;

  localparam int STALL_NONE     = 0;
  localparam int STALL_PERIODIC = 1;
  localparam int STALL_LFSR     = 2;

  localparam int MAX_LATENCY = 8;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 of a right-shifting Fibonacci register land on bits 0,2,3,5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return {^(state & LFSR_TAPS), state[15:1]};
  endfunction

endpackage

// File: rtl/matrix_rd_pipe.sv
// Fixed-latency valid+data delay line for read responses; the output word is
// forced to zero whenever the valid bit is low.
module matrix_rd_pipe #(
  parameter int DATA_W  = 256,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_vld,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_vld,
  output logic [DATA_W-1:0] rsp_data
);

  logic [LATENCY-1:0] vld_reg;
  logic [DATA_W-1:0]  data_reg [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_reg <= '0;
    end else begin
      vld_reg[0] <= req_vld;
      for (int i = 1; i < LATENCY; i++) begin
        vld_reg[i] <= vld_reg[i-1];
      end
    end
  end

  // Data stages carry no reset; stale words are hidden by the output mask.
  genvar gi;
  for (gi = 0; gi < LATENCY; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      always_ff @(posedge clk) data_reg[gi] <= req_data;
    end else begin : g_tail
      always_ff @(posedge clk) data_reg[gi] <= data_reg[gi-1];
    end
  end

  assign rsp_vld  = vld_reg[LATENCY-1];
  assign rsp_data = rsp_vld ? data_reg[LATENCY-1] : '0;

endmodule

// File: rtl/matrix_rd_port.sv
// Read-port model for the GSIM matrix memory: preloadable read-first array,
// configurable read latency, deterministic ready stalls and a read counter.
module matrix_rd_port
  import matrix_mem_pkg::*;
#(
  parameter int DATA_W       = 256,
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 1024,
  parameter int LATENCY      = 1,
  parameter int STALL_MODE   = 0,
  parameter int STALL_PERIOD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_rreq,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_rrdy,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_dout_vld,
  input  logic              i_stall_en,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [31:0]       o_rd_cnt
);

  localparam int              IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM  = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      PHASE_LAST = 8'(STALL_PERIOD - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              rd_in_range;
  logic              wr_in_range;
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        phase_reg;
  logic [7:0]        phase_next;
  logic [15:0]       lfsr_reg;
  logic [15:0]       lfsr_next;
  logic              stall_next;
  logic              rrdy_reg;
  logic [31:0]       rd_cnt_reg;

  assign accept      = i_rreq & rrdy_reg;
  assign rd_in_range = ({1'b0, i_addr} < DEPTH_LIM);
  assign wr_in_range = ({1'b0, i_waddr} < DEPTH_LIM);

  always_ff @(posedge clk) begin
    if (i_wen && wr_in_range) begin
      mem[i_waddr[IDX_W-1:0]] <= i_wdata;
    end
  end

  // Sampled into the first pipe stage at the accepting edge, before the
  // same-edge write lands, so a colliding read returns the old word.
  assign rd_word = rd_in_range ? mem[i_addr[IDX_W-1:0]] : '0;

  assign phase_next = (phase_reg == PHASE_LAST) ? 8'd0 : phase_reg + 8'd1;
  assign lfsr_next  = lfsr_step(lfsr_reg);

  always_comb begin
    stall_next = 1'b0;
    case (STALL_MODE)
      STALL_PERIODIC: stall_next = (phase_next == PHASE_LAST);
      STALL_LFSR:     stall_next = (lfsr_next[1:0] == 2'b00);
      default:        stall_next = 1'b0;
    endcase
  end

  // Ready is computed from the next stall state so it stays a pure register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg  <= 8'd0;
      lfsr_reg   <= LFSR_SEED;
      rrdy_reg   <= 1'b1;
      rd_cnt_reg <= 32'd0;
    end else begin
      phase_reg <= phase_next;
      lfsr_reg  <= lfsr_next;
      rrdy_reg  <= ~(i_stall_en & stall_next);
      if (accept) begin
        rd_cnt_reg <= rd_cnt_reg + 32'd1;
      end
    end
  end

  matrix_rd_pipe #(
    .DATA_W  (DATA_W),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .req_vld  (accept),
    .req_data (rd_word),
    .rsp_vld  (o_dout_vld),
    .rsp_data (o_dout)
  );

  assign o_rrdy   = rrdy_reg;
  assign o_rd_cnt = rd_cnt_reg;

endmodule

// File: tb/tb_matrix_rd_port.sv
// Bench for matrix_rd_port: three builds (latency 1/no stall, latency 4/periodic,
// latency 3/LFSR) share one stimulus stream and are checked against a cycle model.
`timescale 1ns/1ps
module tb_matrix_rd_port;

  localparam int DW  = 64;
  localparam int AW  = 10;
  localparam int DEP = 512;
  localparam int NI  = 3;
  localparam int PER = 4;
  localparam int LAT [NI] = '{1, 4, 3};

  logic          clk = 1'b0;
  logic          reset;
  logic          rreq;
  logic          stall_en;
  logic          wen;
  logic [AW-1:0] addr;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  logic          rrdy [NI];
  logic          vld  [NI];
  logic [DW-1:0] dout [NI];
  logic [31:0]   cnt  [NI];

  always #5 clk = ~clk;

  matrix_rd_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(1),
                   .STALL_MODE(0), .STALL_PERIOD(PER)) u_a (
    .clk(clk), .reset(reset), .i_rreq(rreq), .i_addr(addr), .o_rrdy(rrdy[0]),
    .o_dout(dout[0]), .o_dout_vld(vld[0]), .i_stall_en(stall_en), .i_wen(wen),
    .i_waddr(waddr), .i_wdata(wdata), .o_rd_cnt(cnt[0]));

  matrix_rd_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(4),
                   .STALL_MODE(1), .STALL_PERIOD(PER)) u_b (
    .clk(clk), .reset(reset), .i_rreq(rreq), .i_addr(addr), .o_rrdy(rrdy[1]),
    .o_dout(dout[1]), .o_dout_vld(vld[1]), .i_stall_en(stall_en), .i_wen(wen),
    .i_waddr(waddr), .i_wdata(wdata), .o_rd_cnt(cnt[1]));

  matrix_rd_port #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(3),
                   .STALL_MODE(2), .STALL_PERIOD(PER)) u_c (
    .clk(clk), .reset(reset), .i_rreq(rreq), .i_addr(addr), .o_rrdy(rrdy[2]),
    .o_dout(dout[2]), .o_dout_vld(vld[2]), .i_stall_en(stall_en), .i_wen(wen),
    .i_waddr(waddr), .i_wdata(wdata), .o_rd_cnt(cnt[2]));

  int            tests = 0;
  int            fails = 0;
  bit            run = 1'b0;
  int            n;
  logic [15:0]   lfsr_m;
  logic [DW-1:0] mem_m [DEP];
  bit            acc_h [NI][16];
  logic [DW-1:0] dat_h [NI][16];
  logic          exp_rrdy [NI];
  logic          exp_vld  [NI];
  logic [DW-1:0] exp_dout [NI];
  logic [31:0]   exp_cnt  [NI];

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    lfsr_m = 16'hACE1;
    for (int i = 0; i < NI; i++) begin
      exp_rrdy[i] = 1'b1;
      exp_vld[i]  = 1'b0;
      exp_dout[i] = '0;
      exp_cnt[i]  = 32'd0;
      for (int s = 0; s < 16; s++) acc_h[i][s] = 1'b0;
    end
  endtask

  // One clock edge of the reference: responses appear LAT-1 edges after acceptance.
  task automatic model_step();
    logic [DW-1:0] rd;
    int k;
    bit acc;
    n++;
    rd = (int'(addr) < DEP) ? mem_m[addr[8:0]] : '0;
    for (int i = 0; i < NI; i++) begin
      acc = rreq && exp_rrdy[i];
      acc_h[i][n % 16] = acc;
      dat_h[i][n % 16] = rd;
      if (acc) exp_cnt[i] = exp_cnt[i] + 32'd1;
    end
    if (wen && int'(waddr) < DEP) mem_m[waddr[8:0]] = wdata;
    for (int i = 0; i < NI; i++) begin
      k = n - LAT[i] + 1;
      exp_vld[i]  = 1'b0;
      exp_dout[i] = '0;
      if (k >= 1 && acc_h[i][k % 16]) begin
        exp_vld[i]  = 1'b1;
        exp_dout[i] = dat_h[i][k % 16];
      end
    end
    lfsr_m = lfsr_ref(lfsr_m);
    exp_rrdy[0] = 1'b1;
    exp_rrdy[1] = !(stall_en && (n % PER) == PER - 1);
    exp_rrdy[2] = !(stall_en && lfsr_m[1:0] == 2'b00);
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("rrdy[%0d]", i), DW'(rrdy[i]), DW'(exp_rrdy[i]));
      check($sformatf("vld[%0d]", i),  DW'(vld[i]),  DW'(exp_vld[i]));
      check($sformatf("dout[%0d]", i), dout[i],      exp_dout[i]);
      check($sformatf("cnt[%0d]", i),  DW'(cnt[i]),  DW'(exp_cnt[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    @(negedge clk);
    if (run) compare_all();
  endtask

  logic [3:0]    pin_b;
  logic [3:0]    pin_c;
  logic [7:0]    b8;
  logic [DW-1:0] ones;

  initial begin
    reset = 1'b1; rreq = 1'b0; addr = '0; stall_en = 1'b0;
    wen = 1'b0; waddr = '0; wdata = '0;
    pin_b = 4'b1011;
    pin_c = 4'b1000;
    ones  = '1;
    model_reset();
    repeat (3) tick();
    run = 1'b1;
    #2 reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("rst_rrdy", DW'(rrdy[i]), DW'(1));
      check("rst_vld",  DW'(vld[i]),  DW'(0));
      check("rst_dout", dout[i],      '0);
      check("rst_cnt",  DW'(cnt[i]),  DW'(0));
    end

    // Ready pattern of the first four edges after reset with stalls enabled.
    stall_en = 1'b1;
    for (int m = 0; m < 4; m++) begin
      tick();
      check("pin_periodic", DW'(rrdy[1]), DW'(pin_b[m]));
      check("pin_lfsr",     DW'(rrdy[2]), DW'(pin_c[m]));
    end

    stall_en = 1'b0;
    for (int a = 0; a < DEP; a++) begin
      b8 = 8'(a);
      wen = 1'b1;
      waddr = AW'(a);
      wdata = (a < 16) ? {8{b8}} : {$urandom, $urandom};
      tick();
    end
    wen = 1'b0;

    for (int a = 0; a < 16; a++) begin
      b8 = 8'(a);
      rreq = 1'b1;
      addr = AW'(a);
      tick();
      check("seq_vld",  DW'(vld[0]), DW'(1));
      check("seq_dout", dout[0],     {8{b8}});
    end
    rreq = 1'b0;
    check("seq_cnt", DW'(cnt[0]), DW'(16));

    repeat (8) tick();
    rreq = 1'b1;
    addr = AW'(5);
    b8 = 8'h05;
    for (int j = 1; j <= 6; j++) begin
      tick();
      rreq = 1'b0;
      check("lat4_vld",  DW'(vld[1]), DW'(j == 4));
      check("lat4_dout", dout[1],     (j == 4) ? {8{b8}} : '0);
    end

    rreq = 1'b1; addr = AW'(7);
    wen = 1'b1; waddr = AW'(7); wdata = ones;
    b8 = 8'h07;
    tick();
    wen = 1'b0;
    check("coll_old", dout[0], {8{b8}});
    tick();
    check("coll_new", dout[0], ones);
    addr = AW'(600);
    tick();
    check("oor_vld",  DW'(vld[0]), DW'(1));
    check("oor_dout", dout[0],     '0);
    rreq = 1'b0;

    repeat (2000) begin
      stall_en = ($urandom % 4) != 0;
      rreq     = ($urandom % 4) != 0;
      wen      = ($urandom % 3) == 0;
      waddr    = AW'($urandom_range(0, 639));
      addr     = (($urandom % 4) == 0) ? waddr : AW'($urandom_range(0, 639));
      wdata    = {$urandom, $urandom};
      tick();
    end

    rreq = 1'b0; wen = 1'b0; stall_en = 1'b0;
    tick();
    check("noen_rrdy", DW'(rrdy[2]), DW'(1));
    repeat (5) tick();

    // Two reads into the latency-3 build, then reset before either returns.
    rreq = 1'b1; addr = AW'(1);
    tick();
    addr = AW'(2);
    tick();
    rreq = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    tick();
    tick();
    #2 reset = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      check("rif_vld",  DW'(vld[2]),  DW'(0));
      check("rif_dout", dout[2],      '0);
      check("rif_rrdy", DW'(rrdy[2]), DW'(1));
      check("rif_cnt",  DW'(cnt[2]),  DW'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
